// File: rtl/bno055_i2c_target.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : bno055_i2c_target                                               |
// | Purpose  : I2C target answering at the BNO055 address. Handles pointer     |
// |            writes, burst register writes and burst register reads, and    |
// |            presents them on a simple parallel register port.              |
// | Ports    : i_clk/i_rst   system clock (>= 20x SCL), sync active-high rst   |
// |            i_scl/io_sda  bus lines; SDA is open-drain (0 or released)     |
// |            o_reg_addr    current register pointer                         |
// |            o_wr_en/o_wr_data  one-cycle write strobe and byte             |
// |            o_rd_req/i_rd_data one-cycle read request, data sampled 2      |
// |                          cycles later                                     |
// |            o_busy        transaction in progress for this target          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module bno055_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h28
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  inout  wire        io_sda,
  output logic [7:0] o_reg_addr,
  output logic       o_wr_en,
  output logic [7:0] o_wr_data,
  output logic       o_rd_req,
  input  logic [7:0] i_rd_data,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  state_t      state;
  logic [1:0]  scl_sync;
  logic [1:0]  sda_sync;
  logic        scl_dly;
  logic        sda_dly;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  tx;
  logic        rw;
  logic        sda_oe;
  logic        ack_on;      // ACK low currently driven in an ACK state
  logic        ack_ok;      // initiator ACKed a read byte, continue on next fall
  logic [1:0]  rd_pipe;     // delays o_rd_req to the i_rd_data sample point
  logic        drive_first; // put MSB of freshly latched read byte on the bus

  logic scl_now, sda_now, scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_now   = scl_sync[1];
  assign sda_now   = sda_sync[1];
  assign scl_rise  = scl_now & ~scl_dly;
  assign scl_fall  = ~scl_now & scl_dly;
  assign start_det = scl_now & scl_dly & sda_dly & ~sda_now;
  assign stop_det  = scl_now & scl_dly & ~sda_dly & sda_now;
  assign rx_byte   = {shreg[6:0], sda_now};

  assign io_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync    <= 2'b11;
      sda_sync    <= 2'b11;
      scl_dly     <= 1'b1;
      sda_dly     <= 1'b1;
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'h00;
      tx          <= 8'h00;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      ack_on      <= 1'b0;
      ack_ok      <= 1'b0;
      rd_pipe     <= 2'b00;
      drive_first <= 1'b0;
      o_reg_addr  <= 8'h00;
      o_wr_en     <= 1'b0;
      o_wr_data   <= 8'h00;
      o_rd_req    <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[0], i_scl};
      sda_sync <= {sda_sync[0], io_sda};
      scl_dly  <= scl_sync[1];
      sda_dly  <= sda_sync[1];
      o_wr_en  <= 1'b0;
      o_rd_req <= 1'b0;
      rd_pipe  <= {rd_pipe[0], o_rd_req};

      // Pointer advances the cycle after the write strobe was seen.
      if (o_wr_en) o_reg_addr <= o_reg_addr + 8'd1;

      if (rd_pipe[1]) begin
        tx          <= i_rd_data;
        drive_first <= 1'b1;
      end
      if (drive_first) begin
        drive_first <= 1'b0;
        if (state == ST_RDATA) sda_oe <= ~tx[7];
      end

      if (start_det) begin
        state   <= ST_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        ack_on  <= 1'b0;
        ack_ok  <= 1'b0;
      end else if (stop_det) begin
        state  <= ST_IDLE;
        sda_oe <= 1'b0;
        o_busy <= 1'b0;
        ack_on <= 1'b0;
        ack_ok <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_WAIT_STOP: ;
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (state == ST_ADDR) begin
                  if (shreg[6:0] == DEV_ADDR) begin
                    state  <= ST_ADDR_ACK;
                    o_busy <= 1'b1;
                    rw     <= sda_now;
                  end else begin
                    state  <= ST_WAIT_STOP;
                    o_busy <= 1'b0;
                  end
                end else if (state == ST_PTR) begin
                  o_reg_addr <= rx_byte;
                  state      <= ST_PTR_ACK;
                end else begin
                  o_wr_en   <= 1'b1;
                  o_wr_data <= rx_byte;
                  state     <= ST_WDATA_ACK;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
            // First fall starts the ACK low, second fall ends it.
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe  <= 1'b0;
                ack_on  <= 1'b0;
                bit_cnt <= 4'd0;
                if (state == ST_ADDR_ACK && rw) begin
                  state    <= ST_RDATA;
                  o_rd_req <= 1'b1;
                end else begin
                  state <= (state == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                end
              end
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_RDATA_ACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_now) begin
                o_reg_addr <= o_reg_addr + 8'd1;
                ack_ok     <= 1'b1;
              end else begin
                state  <= ST_WAIT_STOP;
                o_busy <= 1'b0;
              end
            end else if (scl_fall && ack_ok) begin
              ack_ok   <= 1'b0;
              o_rd_req <= 1'b1;
              bit_cnt  <= 4'd0;
              state    <= ST_RDATA;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bno055_i2c_target.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_bno055_i2c_target                                            |
// | Purpose  : Bus-level bench for bno055_i2c_target: an I2C initiator model   |
// |            drives SCL/SDA, a register memory answers read requests, and   |
// |            expected write/read strobes are queued and checked on output.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_bno055_i2c_target;
  localparam int Q = 60;   // quarter SCL period (SCL = 24 clk cycles)

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_drv_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, rd_req, busy;
  logic [7:0] mem [256];
  logic       rd_d1 = 1'b0, rd_d2 = 1'b0;
  logic       prev_wr = 1'b0, prev_rd = 1'b0;
  int         checks = 0, failures = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];

  assign sda_bus = sda_drv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  bno055_i2c_target #(.DEV_ADDR(7'h28)) dut (
    .i_clk(clk), .i_rst(rst), .i_scl(scl), .io_sda(sda_bus),
    .o_reg_addr(reg_addr), .o_wr_en(wr_en), .o_wr_data(wr_data),
    .o_rd_req(rd_req), .i_rd_data(rd_data), .o_busy(busy)
  );

  // Read data is only valid exactly two cycles after the request.
  always @(posedge clk) begin
    rd_d1 <= rd_req;
    rd_d2 <= rd_d1;
  end
  assign rd_data = rd_d2 ? mem[reg_addr] : 8'hC3;

  // Scoreboard: strobes pop and compare against queued expectations.
  always @(negedge clk) begin
    logic [15:0] ew;
    logic [7:0]  er;
    if (wr_en) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", reg_addr, wr_data);
      end else begin
        ew = wr_q.pop_front();
        if ({reg_addr, wr_data} !== ew) begin
          failures++;
          $display("FAIL wr_strobe: got addr=%h data=%h, required addr=%h data=%h",
                   reg_addr, wr_data, ew[15:8], ew[7:0]);
        end
      end
    end
    if (rd_req) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got addr=%h, required no read request", reg_addr);
      end else begin
        er = rd_q.pop_front();
        if (reg_addr !== er) begin
          failures++;
          $display("FAIL rd_req_addr: got %h, required %h", reg_addr, er);
        end
      end
    end
    if ((wr_en && prev_wr) || (rd_req && prev_rd) || (wr_en && rd_req)) begin
      failures++;
      $display("FAIL pulse_shape: got wr=%b/%b rd=%b/%b, required single non-overlapping pulses",
               prev_wr, wr_en, prev_rd, rd_req);
    end
    prev_wr = wr_en;
    prev_rd = rd_req;
  end

  // ---------------- initiator primitives ----------------
  task automatic bus_start();
    sda_drv_low = 1'b0; #Q; scl = 1'b1; #Q; sda_drv_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_drv_low = 1'b1; #Q; scl = 1'b1; #Q; sda_drv_low = 1'b0; #Q;
  endtask

  task automatic write_bit(input logic b);
    sda_drv_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic read_bit(output logic b);
    sda_drv_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(nack);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({reg_addr, wr_en, wr_data, rd_req, busy, sda_bus} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got addr=%h wr=%b wd=%h rd=%b busy=%b sda=%b, required 00 0 00 0 0 1",
               reg_addr, wr_en, wr_data, rd_req, busy, sda_bus);
    end
  endtask

  task automatic test_single_write();
    logic a0, a1, a2;
    bus_start();
    write_byte(8'h50, a0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b, required 1", busy); end
    write_byte(8'h3D, a1);
    wr_q.push_back({8'h3D, 8'h0C});
    write_byte(8'h0C, a2);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin
      failures++; $display("FAIL write_acks: got %b, required 000", {a0, a1, a2});
    end
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_stop: got %b, required 0", busy); end
    checks++;
    if (reg_addr !== 8'h3E) begin failures++; $display("FAIL write_ptr: got %h, required 3e", reg_addr); end
    checks++;
    if (wr_q.size() != 0) begin failures++; $display("FAIL write_missing: got %0d pending, required 0", wr_q.size()); end
  endtask

  task automatic test_read_single();
    logic a0, a1, a2;
    logic [7:0] d;
    mem[8'h00] = 8'hA0;
    bus_start();
    write_byte(8'h50, a0);
    write_byte(8'h00, a1);
    bus_start();
    rd_q.push_back(8'h00);
    write_byte(8'h51, a2);
    read_byte(1'b1, d);
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL read_acks: got %b, required 000", {a0, a1, a2}); end
    checks++;
    if (d !== 8'hA0) begin failures++; $display("FAIL read_data: got %h, required a0", d); end
    checks++;
    if (reg_addr !== 8'h00) begin failures++; $display("FAIL read_nack_ptr: got %h, required 00", reg_addr); end
    checks++;
    if (rd_q.size() != 0) begin failures++; $display("FAIL read_missing: got %0d pending, required 0", rd_q.size()); end
  endtask

  task automatic test_burst_wrap();
    logic a;
    logic [7:0] bytes_out [3];
    bytes_out[0] = 8'h11; bytes_out[1] = 8'h22; bytes_out[2] = 8'h33;
    bus_start();
    write_byte(8'h50, a);
    write_byte(8'hFE, a);
    for (int i = 0; i < 3; i++) begin
      wr_q.push_back({8'hFE + 8'(i), bytes_out[i]});
      write_byte(bytes_out[i], a);
      checks++;
      if (a !== 1'b0) begin failures++; $display("FAIL burst_ack%0d: got %b, required 0", i, a); end
    end
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (reg_addr !== 8'h01) begin failures++; $display("FAIL burst_ptr: got %h, required 01", reg_addr); end
    checks++;
    if (wr_q.size() != 0) begin failures++; $display("FAIL burst_missing: got %0d pending, required 0", wr_q.size()); end
  endtask

  task automatic test_addr_nack();
    logic a;
    bus_start();
    write_byte(8'h52, a);
    checks++;
    if (a !== 1'b1) begin failures++; $display("FAIL nack_ack: got %b, required 1", a); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL nack_busy: got %b, required 0", busy); end
    write_byte(8'h99, a);
    checks++;
    if (a !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL nack_ignored: got ack=%b busy=%b, required 1 0", a, busy);
    end
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (reg_addr !== 8'h01) begin failures++; $display("FAIL nack_ptr: got %h, required 01", reg_addr); end
  endtask

  task automatic test_read_burst();
    logic a;
    logic [7:0] d;
    for (int i = 0; i < 3; i++) mem[8'h10 + 8'(i)] = 8'($urandom);
    bus_start();
    write_byte(8'h50, a);
    write_byte(8'h10, a);
    bus_start();
    for (int i = 0; i < 3; i++) rd_q.push_back(8'h10 + 8'(i));
    write_byte(8'h51, a);
    for (int i = 0; i < 3; i++) begin
      read_byte(i == 2, d);
      checks++;
      if (d !== mem[8'h10 + 8'(i)]) begin
        failures++; $display("FAIL burst_read%0d: got %h, required %h", i, d, mem[8'h10 + 8'(i)]);
      end
    end
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (reg_addr !== 8'h12) begin failures++; $display("FAIL burst_read_ptr: got %h, required 12", reg_addr); end
    checks++;
    if (rd_q.size() != 0) begin failures++; $display("FAIL burst_read_missing: got %0d pending, required 0", rd_q.size()); end
  endtask

  task automatic test_reset_mid_read();
    logic a, b;
    mem[8'h40] = 8'h00;
    bus_start();
    write_byte(8'h50, a);
    write_byte(8'h40, a);
    bus_start();
    rd_q.push_back(8'h40);
    write_byte(8'h51, a);
    for (int i = 0; i < 5; i++) read_bit(b);
    checks++;
    if (sda_bus !== 1'b0) begin failures++; $display("FAIL mid_read_drive: got %b, required 0", sda_bus); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({sda_bus, reg_addr, wr_en, wr_data, rd_req, busy} !== {1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset_values: got sda=%b addr=%h wr=%b wd=%h rd=%b busy=%b, required 1 00 0 00 0 0",
               sda_bus, reg_addr, wr_en, wr_data, rd_req, busy);
    end
    bus_stop();
    bus_start();
    write_byte(8'h50, a);
    checks++;
    if (a !== 1'b0) begin failures++; $display("FAIL post_reset_ack: got %b, required 0", a); end
    write_byte(8'h20, a);
    wr_q.push_back({8'h20, 8'h77});
    write_byte(8'h77, a);
    bus_stop();
    repeat (6) @(negedge clk);
    checks++;
    if (reg_addr !== 8'h21 || wr_q.size() != 0) begin
      failures++; $display("FAIL post_reset_write: got ptr=%h pending=%0d, required 21 0", reg_addr, wr_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    test_reset();
    test_single_write();
    test_read_single();
    test_burst_wrap();
    test_addr_nack();
    test_read_burst();
    test_reset_mid_read();
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
